// File: rtl/mccpu_ctrl_pkg.sv
// Shared control encodings for the RV32I datapath: immediate, ALU, next-PC and
// write-data selects, plus the multi-cycle sequencer state codes.
package ctrl_encode_def;

  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

  localparam logic [4:0] ALUOp_nop  = 5'b00000;
  localparam logic [4:0] ALUOp_lui  = 5'b00001;
  localparam logic [4:0] ALUOp_auipc = 5'b00010;
  localparam logic [4:0] ALUOp_add  = 5'b00011;
  localparam logic [4:0] ALUOp_sub  = 5'b00100;
  localparam logic [4:0] ALUOp_bne  = 5'b00101;
  localparam logic [4:0] ALUOp_blt  = 5'b00110;
  localparam logic [4:0] ALUOp_bge  = 5'b00111;
  localparam logic [4:0] ALUOp_bltu = 5'b01000;
  localparam logic [4:0] ALUOp_bgeu = 5'b01001;
  localparam logic [4:0] ALUOp_slt  = 5'b01010;
  localparam logic [4:0] ALUOp_sltu = 5'b01011;
  localparam logic [4:0] ALUOp_xor  = 5'b01100;
  localparam logic [4:0] ALUOp_or   = 5'b01101;
  localparam logic [4:0] ALUOp_and  = 5'b01110;
  localparam logic [4:0] ALUOp_sll  = 5'b01111;
  localparam logic [4:0] ALUOp_srl  = 5'b10000;
  localparam logic [4:0] ALUOp_sra  = 5'b10001;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;

  localparam logic [1:0] WDSel_FromALU = 2'b00;
  localparam logic [1:0] WDSel_FromMEM = 2'b01;
  localparam logic [1:0] WDSel_FromPC  = 2'b10;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // One flag per supported instruction class; all-zero means illegal.
  typedef struct packed {
    logic rtype;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic lui;
  } insn_class_t;

endpackage

// File: rtl/mccpu_ctrl_decode.sv
// Combinational instruction decode: class flags and the single-cycle
// control encodings derived from opcode/funct fields.
module mc_decode
  import ctrl_encode_def::*;
(
  input  logic [6:0]  Op,
  input  logic [6:0]  Funct7,
  input  logic [2:0]  Funct3,
  output insn_class_t cls,
  output logic        illegal_dec,
  output logic [5:0]  EXTOp,
  output logic [4:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  WDSel
);

  always_comb begin
    cls    = '0;
    EXTOp  = 6'b000000;
    ALUOp  = ALUOp_nop;
    ALUSrc = 1'b0;
    WDSel  = WDSel_FromALU;
    case (Op)
      OP_RTYPE: begin
        cls.rtype = 1'b1;
        case ({Funct7, Funct3})
          {F7_BASE, 3'b000}: ALUOp = ALUOp_add;
          {F7_ALT,  3'b000}: ALUOp = ALUOp_sub;
          {F7_BASE, 3'b001}: ALUOp = ALUOp_sll;
          {F7_BASE, 3'b100}: ALUOp = ALUOp_xor;
          {F7_BASE, 3'b101}: ALUOp = ALUOp_srl;
          {F7_ALT,  3'b101}: ALUOp = ALUOp_sra;
          {F7_BASE, 3'b110}: ALUOp = ALUOp_or;
          {F7_BASE, 3'b111}: ALUOp = ALUOp_and;
          default:           cls.rtype = 1'b0;
        endcase
      end
      OP_ITYPE: if (Funct3 == 3'b000) begin
        cls.addi = 1'b1;
        EXTOp    = EXT_CTRL_ITYPE;
        ALUOp    = ALUOp_add;
        ALUSrc   = 1'b1;
      end
      OP_LOAD: if (Funct3 == 3'b010) begin
        cls.lw = 1'b1;
        EXTOp  = EXT_CTRL_ITYPE;
        ALUOp  = ALUOp_add;
        ALUSrc = 1'b1;
        WDSel  = WDSel_FromMEM;
      end
      OP_STORE: if (Funct3 == 3'b010) begin
        cls.sw = 1'b1;
        EXTOp  = EXT_CTRL_STYPE;
        ALUOp  = ALUOp_add;
        ALUSrc = 1'b1;
      end
      OP_BRANCH: if (Funct3 == 3'b000) begin
        cls.beq = 1'b1;
        EXTOp   = EXT_CTRL_BTYPE;
        ALUOp   = ALUOp_sub;
      end
      OP_JAL: begin
        cls.jal = 1'b1;
        EXTOp   = EXT_CTRL_JTYPE;
        WDSel   = WDSel_FromPC;
      end
      OP_LUI: begin
        cls.lui = 1'b1;
        EXTOp   = EXT_CTRL_UTYPE;
        ALUOp   = ALUOp_lui;
        ALUSrc  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_dec = ~|cls;

endmodule

// File: rtl/mccpu_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over a single
// req/ready memory port, with strobe generation and a retired-instruction counter.
module mccpu_ctrl
  import ctrl_encode_def::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MDRWrite,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic             ALUSrc,
  output logic [5:0]       EXTOp,
  output logic [4:0]       ALUOp,
  output logic [2:0]       NPCOp,
  output logic [1:0]       WDSel,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_t      state, state_nx;
  insn_class_t cls;
  logic        illegal_dec;

  mc_decode u_decode (
    .Op          (Op),
    .Funct7      (Funct7),
    .Funct3      (Funct3),
    .cls         (cls),
    .illegal_dec (illegal_dec),
    .EXTOp       (EXTOp),
    .ALUOp       (ALUOp),
    .ALUSrc      (ALUSrc),
    .WDSel       (WDSel)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Moore strobes per state; only mem_ready and Zero gate anything.
  always_comb begin
    state_nx = S_IDLE;
    MemReq   = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MDRWrite = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = NPC_PLUS4;
    illegal  = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        MemReq   = 1'b1;
        state_nx = S_FETCH;
        if (mem_ready) begin
          IRWrite  = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal_dec) begin
          illegal  = 1'b1;
          PCWrite  = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.beq) begin
          PCWrite  = 1'b1;
          NPCOp    = Zero ? NPC_BRANCH : NPC_PLUS4;
          state_nx = S_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_nx = S_MEM;
        end else if (cls.rtype || cls.addi || cls.lui || cls.jal) begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        MemReq   = 1'b1;
        IorD     = 1'b1;
        MemWrite = cls.sw;
        state_nx = S_MEM;
        if (mem_ready) begin
          if (cls.sw) begin
            PCWrite  = 1'b1;
            state_nx = S_FETCH;
          end else begin
            MDRWrite = 1'b1;
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        NPCOp    = cls.jal ? NPC_JUMP : NPC_PLUS4;
        state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign state_o = state;

  // Every PC update retires an instruction, except the skip over an illegal one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   instret <= '0;
    else if (PCWrite && !illegal) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Self-checking bench for mccpu_ctrl: per-instruction phase model plus
// hand-computed literal expectations.
module tb_mccpu_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             Zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic [31:0]      ir = 32'h0;
  logic [31:0]      cur_instr = 32'h0;
  logic             MemReq, MemWrite, IorD, IRWrite, MDRWrite, RegWrite, PCWrite, ALUSrc, illegal;
  logic [5:0]       EXTOp;
  logic [4:0]       ALUOp;
  logic [2:0]       NPCOp;
  logic [1:0]       WDSel;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  mccpu_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .Op        (ir[6:0]),
    .Funct7    (ir[31:25]),
    .Funct3    (ir[14:12]),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .MDRWrite  (MDRWrite),
    .RegWrite  (RegWrite),
    .PCWrite   (PCWrite),
    .ALUSrc    (ALUSrc),
    .EXTOp     (EXTOp),
    .ALUOp     (ALUOp),
    .NPCOp     (NPCOp),
    .WDSel     (WDSel),
    .illegal   (illegal),
    .state_o   (state_o),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  // Instruction register of the surrounding datapath.
  always @(posedge clk) if (IRWrite) ir <= cur_instr;

  typedef enum {K_ILL, K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_JAL, K_LUI} kind_t;

  typedef struct {
    kind_t      kind;
    logic [4:0] alu;
    logic [5:0] ext;
    logic       src;
    logic [1:0] wd;
  } dref_t;

  typedef struct {
    int st;
    bit memreq, memwrite, iord, irwrite, mdrwrite, regwrite, pcwrite, ill;
    int npc;
  } exp_t;

  // Instruction table: mnemonic pattern -> expected decode fields.
  function automatic dref_t ref_decode(input logic [31:0] w);
    dref_t d;
    d.kind = K_ILL; d.alu = 5'b00000; d.ext = 6'b000000; d.src = 1'b0; d.wd = 2'b00;
    casez ({w[31:25], w[14:12], w[6:0]})
      17'b0000000_000_0110011: begin d.kind = K_R; d.alu = 5'b00011; end
      17'b0100000_000_0110011: begin d.kind = K_R; d.alu = 5'b00100; end
      17'b0000000_001_0110011: begin d.kind = K_R; d.alu = 5'b01111; end
      17'b0000000_100_0110011: begin d.kind = K_R; d.alu = 5'b01100; end
      17'b0000000_101_0110011: begin d.kind = K_R; d.alu = 5'b10000; end
      17'b0100000_101_0110011: begin d.kind = K_R; d.alu = 5'b10001; end
      17'b0000000_110_0110011: begin d.kind = K_R; d.alu = 5'b01101; end
      17'b0000000_111_0110011: begin d.kind = K_R; d.alu = 5'b01110; end
      17'b???????_000_0010011: begin d.kind = K_ADDI; d.alu = 5'b00011; d.ext = 6'b010000; d.src = 1'b1; end
      17'b???????_010_0000011: begin d.kind = K_LW; d.alu = 5'b00011; d.ext = 6'b010000; d.src = 1'b1; d.wd = 2'b01; end
      17'b???????_010_0100011: begin d.kind = K_SW; d.alu = 5'b00011; d.ext = 6'b001000; d.src = 1'b1; end
      17'b???????_000_1100011: begin d.kind = K_BEQ; d.alu = 5'b00100; d.ext = 6'b000100; end
      17'b???????_???_1101111: begin d.kind = K_JAL; d.ext = 6'b000001; d.wd = 2'b10; end
      17'b???????_???_0110111: begin d.kind = K_LUI; d.alu = 5'b00001; d.ext = 6'b000010; d.src = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic exp_t blank(input int st);
    exp_t e;
    e.st = st; e.memreq = 0; e.memwrite = 0; e.iord = 0; e.irwrite = 0;
    e.mdrwrite = 0; e.regwrite = 0; e.pcwrite = 0; e.ill = 0; e.npc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  int unsigned model_instret = 0;
  int n_cyc, n_iord, n_mdr, n_memwrite, n_regwrite, n_ill;
  logic [4:0] last_wb_alu;
  logic [5:0] last_wb_ext;
  logic [2:0] last_wb_npc, last_exec_npc;
  logic [1:0] last_wb_wd;

  // One cycle: drive inputs, compare every output at the falling edge.
  task automatic step(input exp_t e, input logic mr, input bit want_dec, input dref_t d);
    mem_ready = mr;
    @(negedge clk);
    check("state",    32'(state_o),  32'(e.st));
    check("MemReq",   32'(MemReq),   32'(e.memreq));
    check("MemWrite", 32'(MemWrite), 32'(e.memwrite));
    check("IorD",     32'(IorD),     32'(e.iord));
    check("IRWrite",  32'(IRWrite),  32'(e.irwrite));
    check("MDRWrite", 32'(MDRWrite), 32'(e.mdrwrite));
    check("RegWrite", 32'(RegWrite), 32'(e.regwrite));
    check("PCWrite",  32'(PCWrite),  32'(e.pcwrite));
    check("illegal",  32'(illegal),  32'(e.ill));
    if (e.pcwrite) check("NPCOp", 32'(NPCOp), 32'(e.npc));
    check("instret",  instret,       model_instret);
    if (want_dec) begin
      check("ALUOp",  32'(ALUOp),  32'(d.alu));
      check("EXTOp",  32'(EXTOp),  32'(d.ext));
      check("ALUSrc", 32'(ALUSrc), 32'(d.src));
      check("WDSel",  32'(WDSel),  32'(d.wd));
    end
    n_cyc++;
    if (IorD && MemReq) n_iord++;
    if (MDRWrite) n_mdr++;
    if (MemWrite) n_memwrite++;
    if (RegWrite) n_regwrite++;
    if (illegal)  n_ill++;
    if (e.st == 5) begin
      last_wb_alu = ALUOp; last_wb_ext = EXTOp; last_wb_npc = NPCOp; last_wb_wd = WDSel;
    end
    if (e.st == 3) last_exec_npc = NPCOp;
    if (e.pcwrite && !e.ill) model_instret++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Walk one instruction through its phases from the spec rules.
  task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic z);
    dref_t d;
    exp_t  e;
    d = ref_decode(w);
    cur_instr = w;
    Zero = z;
    n_cyc = 0; n_iord = 0; n_mdr = 0; n_memwrite = 0; n_regwrite = 0; n_ill = 0;
    for (int i = 0; i <= fw; i++) begin
      e = blank(1); e.memreq = 1; e.irwrite = (i == fw);
      step(e, logic'(i == fw), 0, d);
    end
    e = blank(2);
    if (d.kind == K_ILL) begin
      e.pcwrite = 1; e.ill = 1;
      step(e, rnd(), 1, d);
      return;
    end
    step(e, rnd(), 1, d);
    e = blank(3);
    if (d.kind == K_BEQ) begin
      e.pcwrite = 1; e.npc = z ? 1 : 0;
      step(e, rnd(), 1, d);
      return;
    end
    step(e, rnd(), 1, d);
    if (d.kind == K_LW || d.kind == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        e = blank(4); e.memreq = 1; e.iord = 1; e.memwrite = (d.kind == K_SW);
        if (i == mw) begin
          if (d.kind == K_SW) e.pcwrite = 1;
          else                e.mdrwrite = 1;
        end
        step(e, logic'(i == mw), 1, d);
      end
      if (d.kind == K_SW) return;
    end
    e = blank(5); e.regwrite = 1; e.pcwrite = 1; e.npc = (d.kind == K_JAL) ? 2 : 0;
    step(e, rnd(), 1, d);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_state"},   32'(state_o),  32'd0);
    check({tag, "_MemReq"},  32'(MemReq),   32'd0);
    check({tag, "_MemWrite"},32'(MemWrite), 32'd0);
    check({tag, "_IRWrite"}, 32'(IRWrite),  32'd0);
    check({tag, "_MDRWrite"},32'(MDRWrite), 32'd0);
    check({tag, "_RegWrite"},32'(RegWrite), 32'd0);
    check({tag, "_PCWrite"}, 32'(PCWrite),  32'd0);
    check({tag, "_illegal"}, 32'(illegal),  32'd0);
    check({tag, "_instret"}, instret,       32'd0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic [31:0] extra [8] = '{32'h40208133, 32'h4020D1B3, 32'h00108093, 32'h123450B7,
                             32'h0020A1B3, 32'h0020C1B3, 32'h00209133, 32'h0020F1B3};

  initial begin
    dref_t d;
    exp_t  e;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rstn = 1'b1;
    d = ref_decode(32'h0);
    step(blank(0), 1'b1, 0, d);

    run_instr(I_ADD, 0, 0, 1'b0);
    check("add_cycles",   n_cyc, 4);
    check("add_aluop",    32'(last_wb_alu), 32'b00011);
    check("add_npc",      32'(last_wb_npc), 32'b000);
    check("add_regwrite", n_regwrite, 1);
    check("add_instret",  instret, 1);

    run_instr(I_LW, 0, 2, 1'b0);
    check("lw_cycles",   n_cyc, 7);
    check("lw_iord",     n_iord, 3);
    check("lw_mdr",      n_mdr, 1);
    check("lw_wdsel",    32'(last_wb_wd), 32'b01);
    check("lw_instret",  instret, 2);

    run_instr(I_SW, 1, 0, 1'b0);
    check("sw_cycles",   n_cyc, 5);
    check("sw_memwrite", n_memwrite, 1);
    check("sw_regwrite", n_regwrite, 0);
    check("sw_instret",  instret, 3);

    run_instr(I_BEQ, 0, 0, 1'b1);
    check("beq_t_npc",    32'(last_exec_npc), 32'b001);
    check("beq_t_cycles", n_cyc, 3);
    run_instr(I_BEQ, 0, 0, 1'b0);
    check("beq_n_npc",    32'(last_exec_npc), 32'b000);
    check("beq_n_cycles", n_cyc, 3);
    check("beq_instret",  instret, 5);

    run_instr(I_JAL, 0, 0, 1'b0);
    check("jal_extop",    32'(last_wb_ext), 32'b000001);
    check("jal_wdsel",    32'(last_wb_wd),  32'b10);
    check("jal_npc",      32'(last_wb_npc), 32'b010);
    check("jal_regwrite", n_regwrite, 1);
    check("jal_instret",  instret, 6);

    run_instr(I_BAD, 0, 0, 1'b0);
    check("ill_pulse",    n_ill, 1);
    check("ill_cycles",   n_cyc, 2);
    check("ill_instret",  instret, 6);

    foreach (extra[i]) run_instr(extra[i], int'($urandom_range(0, 2)), 0, rnd());
    run_instr(I_LW, 2, 1, 1'b1);

    // Abandon a store in S_MEM with an asynchronous reset.
    d = ref_decode(I_SW);
    cur_instr = I_SW;
    e = blank(1); e.memreq = 1; e.irwrite = 1; step(e, 1'b1, 0, d);
    step(blank(2), 1'b1, 1, d);
    step(blank(3), 1'b1, 1, d);
    e = blank(4); e.memreq = 1; e.iord = 1; e.memwrite = 1; step(e, 1'b0, 1, d);
    mem_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check_quiet("midrst");
    check("midrst_IorD", 32'(IorD), 32'd0);
    model_instret = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    d = ref_decode(32'h0);
    step(blank(0), 1'b1, 0, d);
    run_instr(I_SW, 0, 0, 1'b0);
    check("post_rst_instret", instret, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mccpu_ctrl.md
Name: mccpu_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle control with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. The datapath uses one unified memory port with a req/ready handshake. The block emits the existing control encodings (EXTOp, ALUOp, NPCOp, WDSel) plus multi-cycle strobes and a retired-instruction counter.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret.

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
Op  in  7  opcode from the instruction register (IR)
Funct7  in  7  funct7 from IR
Funct3  in  3  funct3 from IR
Zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory completes the current request this cycle
MemReq  out  1  memory request
MemWrite  out  1  write qualifier for MemReq
IorD  out  1  memory address select: 0 = PC, 1 = ALU result
IRWrite  out  1  load IR from read data
MDRWrite  out  1  load memory data register from read data
RegWrite  out  1  register file write
PCWrite  out  1  load PC from the NPC output
ALUSrc  out  1  ALU B operand: 0 = rs2, 1 = immediate
EXTOp  out  6  one-hot immediate select: ITYPE_SHAMT, ITYPE, STYPE, BTYPE, UTYPE, JTYPE
ALUOp  out  5  ALU operation, codes from ctrl_encode_def
NPCOp  out  3  next-PC select: PLUS4 000, BRANCH 001, JUMP 010
WDSel  out  2  write-data select: ALU 00, MEM 01, PC 10
illegal  out  1  one-cycle pulse on an unsupported instruction
state_o  out  3  current state, for debug
instret  out  CNT_W  retired-instruction count

Behaviour:
- Supported instructions: add, sub, and, or, xor, sll, srl, sra, addi, lw, sw, beq, jal, lui. All others are illegal.
- States: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5. Codes 6 and 7 go to S_IDLE.
- Reset (asynchronous, any state):
  - state = S_IDLE, instret = 0.
  - All strobes are 0 while rstn is low and in S_IDLE: MemReq, MemWrite, IRWrite, MDRWrite, RegWrite, PCWrite, illegal.
  - S_IDLE always goes to S_FETCH on the next edge.
  - A reset asserted mid-instruction abandons it with no PC or register write.
- Decode outputs (EXTOp, ALUOp, ALUSrc, WDSel) are combinational from Op/Funct. They are meaningful from S_DECODE onward and use the same codes as single-cycle control.
- S_FETCH:
  - MemReq=1, IorD=0, MemWrite=0.
  - Stays in S_FETCH until mem_ready. The request is held stable while waiting.
  - On mem_ready: IRWrite=1, go to S_DECODE.
- S_DECODE:
  - Legal instruction: go to S_EXEC.
  - Illegal instruction: illegal=1, PCWrite=1, NPCOp=PLUS4, go to S_FETCH. instret does not increment.
- S_EXEC:
  - lw, sw: go to S_MEM.
  - R-type, addi, lui, jal: go to S_WB.
  - beq: PCWrite=1, NPCOp = Zero ? BRANCH : PLUS4, go to S_FETCH.
- S_MEM:
  - MemReq=1, IorD=1, MemWrite = sw.
  - Waits for mem_ready.
  - lw on mem_ready: MDRWrite=1, go to S_WB.
  - sw on mem_ready: PCWrite=1, NPCOp=PLUS4, go to S_FETCH.
- S_WB:
  - RegWrite=1.
  - WDSel: MEM for lw, PC for jal, ALU otherwise.
  - PCWrite=1, NPCOp = JUMP for jal, PLUS4 otherwise.
  - Go to S_FETCH.
- instret increments by 1 on every PCWrite except illegal. It wraps from 2^CNT_W-1 to 0.
- Strobes are a Moore function of state, except where a strobe is gated by mem_ready or Zero.
- MemReq is never asserted in S_DECODE, S_EXEC or S_WB.
- Per-instruction cycles with zero wait states:
  - 3 for beq
  - 4 for R-type, I-type, lui, jal and sw
  - 5 for lw
- Each wait cycle of mem_ready adds 1.

Decomposition:
- Shared package: ctrl_encode_def gains the state codes S_IDLE..S_WB. It keeps the existing EXT_CTRL_*, ALUOp_*, NPC_* and WDSel_* constants.
- Sub-module mc_decode: combinational. Inputs Op, Funct7, Funct3. Outputs per-instruction class flags, illegal_dec, EXTOp, ALUOp, ALUSrc, WDSel.
- mccpu_ctrl holds the FSM, strobe generation and instret.

Test Plan:
- Reset release, mem_ready=1, IR=add (0x002081B3). Required:
  - S_IDLE, FETCH, DECODE, EXEC, WB.
  - RegWrite=1 only in WB, ALUOp=00011, PCWrite=1 with NPCOp=000.
  - instret=1.
- lw (0x0000A183) with mem_ready low for 2 cycles in S_MEM. Required:
  - MemReq=1, IorD=1 held 3 cycles.
  - MDRWrite pulses once.
  - WB has WDSel=01; 7 cycles total.
- sw (0x0030A023). Required:
  - MemWrite=1 in S_MEM only.
  - RegWrite never asserted.
  - PCWrite on the mem_ready cycle.
- beq with Zero=1, then Zero=0. Required:
  - NPCOp=001, then 000, in EXEC.
  - 3 cycles each; instret +2.
- jal (0x008000EF). Required:
  - EXTOp=000001.
  - WB has WDSel=10, NPCOp=010, RegWrite=1.
- IR=0xFFFFFFFF. Required:
  - illegal=1 and PCWrite=1 in DECODE.
  - instret unchanged.
- rstn low mid-S_MEM of sw. Required:
  - Strobes drop to 0 immediately.
  - instret=0.
  - No MemWrite after release until a new fetch.
